// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes, held game keys, and emits one
// stretched pulse per genuine key press (typematic repeats and breaks never retrigger).
module ps2_key_decoder #(
  parameter int PULSE_CYCLES = 4,
  parameter int TIMEOUT      = 250000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       arrowUp,
  output logic       arrowDown,
  output logic       arrowL,
  output logic       arrowR,
  output logic       select,
  output logic [4:0] heldKeys,
  output logic [7:0] lastCode,
  output logic       lastExt
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    CODE_EXT     = 8'hE0;
  localparam logic [7:0]    CODE_BRK     = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t        state;
  logic [TW-1:0] timeout_cnt;
  logic [CW-1:0] pulse_cnt  [5];
  logic [CW-1:0] cnt_next   [5];
  logic [4:0]    pulse_q;
  logic [4:0]    key_match;
  logic [4:0]    held_next;
  logic          in_ext;
  logic          in_brk;
  logic          is_terminal;

  // Key index order matches heldKeys: {select, R, L, Down, Up}.
  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ext      = (state == EXT) || (state == EXT_BRK);
    in_brk      = (state == BRK) || (state == EXT_BRK);
    is_terminal = (ps2_key_data != CODE_EXT) && (ps2_key_data != CODE_BRK);
    key_match   = '0;
    if (ps2_key_pressed && is_terminal) begin
      case (ps2_key_data)
        8'h75:   key_match[0] = 1'b1;
        8'h72:   key_match[1] = 1'b1;
        8'h6B:   key_match[2] = 1'b1;
        8'h74:   key_match[3] = 1'b1;
        8'h29:   key_match[4] = !in_ext;
        default: key_match    = '0;
      endcase
    end
  end

  // A make only loads the stretcher when the key was not already held.
  always_comb begin
    held_next = heldKeys;
    for (int i = 0; i < 5; i++) begin
      cnt_next[i] = pulse_cnt[i];
      if (key_match[i]) held_next[i] = !in_brk;
      if (key_match[i] && !in_brk && !heldKeys[i]) begin
        cnt_next[i] = PULSE_LOAD;
      end else if (pulse_cnt[i] != '0) begin
        cnt_next[i] = pulse_cnt[i] - CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // NOTE: the stretch counters are a small register array, not RAM, so resetting every element is cheap and required.
      for (int i = 0; i < 5; i++) pulse_cnt[i] <= '0;
      state       <= IDLE;
      timeout_cnt <= '0;
      pulse_q     <= '0;
      heldKeys    <= '0;
      lastCode    <= '0;
      lastExt     <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        pulse_cnt[i] <= cnt_next[i];
        pulse_q[i]   <= (cnt_next[i] != '0);
      end
      heldKeys <= held_next;

      if (ps2_key_pressed) begin
        timeout_cnt <= '0;
        if (ps2_key_data == CODE_EXT) begin
          state <= EXT;
        end else if (ps2_key_data == CODE_BRK) begin
          state <= in_ext ? EXT_BRK : BRK;
        end else begin
          state    <= IDLE;
          lastCode <= ps2_key_data;
          lastExt  <= in_ext;
        end
      end else if (state != IDLE) begin
        // An abandoned prefix drops back to IDLE without touching any output.
        if (timeout_cnt == TIMEOUT_LAST) begin
          state       <= IDLE;
          timeout_cnt <= '0;
        end else begin
          timeout_cnt <= timeout_cnt + TW'(1);
        end
      end else begin
        timeout_cnt <= '0;
      end
    end
  end

  assign arrowUp   = pulse_q[0];
  assign arrowDown = pulse_q[1];
  assign arrowL    = pulse_q[2];
  assign arrowR    = pulse_q[3];
  assign select    = pulse_q[4];

endmodule
